// File: rtl/note_seq.sv
// note_seq: score sequencer for the audio output path.
// Walks a synchronous score ROM of {beat_len[8:5], tone_idx[4:0]} entries,
// programs an external beat counter with each note's terminal count and
// drives the tone generator. A muted gap separates consecutive notes.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, stop          1-cycle control pulses from the CPU
//   loop                 level, restart at address 0 on the end marker
//   rom_addr, rom_data   score ROM read port (data valid 1 cycle after addr)
//   beat_en              enable to the beat counter
//   beat_cnt_parameter   beat counter terminal count (len*BEAT_UNIT-1)
//   beat_finish          beat counter terminal-count flag
//   tone_idx, tone_en    note index and audible flag for the tone generator
//   busy                 high in every state except IDLE
//   done                 1-cycle pulse when the end marker ends playback
//
// state | meaning
// IDLE  | stopped, waiting for start
// FETCH | rom_addr presented to the ROM
// WAIT  | ROM read latency
// LOAD  | decode rom_data: end marker or new note
// PLAY  | beat counter running until beat_finish
// GAP   | muted pause between notes
// DONE  | end marker reached, pulse done
module note_seq #(
  parameter int ADDR_W     = 8,
  parameter int BEAT_UNIT  = 12_500_000,
  parameter int GAP_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic              beat_en,
  output logic [27:0]       beat_cnt_parameter,
  input  logic              beat_finish,
  output logic [4:0]        tone_idx,
  output logic              tone_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_GAP, S_DONE
  } state_t;

  localparam logic [27:0]       UNIT28   = 28'(BEAT_UNIT);
  localparam logic [31:0]       GAP_LOAD = 32'(GAP_CYCLES) - 32'd1;
  localparam logic [4:0]        END_MARK = 5'd31;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic        stop_req;
  logic [31:0] gap_cnt;

  logic [3:0]  len_eff;
  logic [4:0]  idx_raw;
  logic [27:0] param_next;
  logic        stop_pend;

  // A zero length entry still plays for one beat unit.
  assign idx_raw    = rom_data[4:0];
  assign len_eff    = (rom_data[8:5] == 4'd0) ? 4'd1 : rom_data[8:5];
  assign param_next = ({24'd0, len_eff} * UNIT28) - 28'd1;
  // A stop arriving on the very edge a note ends still counts.
  assign stop_pend  = stop_req | stop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= S_IDLE;
      stop_req           <= 1'b0;
      gap_cnt            <= '0;
      rom_addr           <= '0;
      beat_en            <= 1'b0;
      beat_cnt_parameter <= '0;
      tone_idx           <= '0;
      tone_en            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != S_IDLE) stop_req <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state    <= S_FETCH;
            rom_addr <= '0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT:  state <= S_LOAD;
        S_LOAD: begin
          if (idx_raw == END_MARK) begin
            rom_addr <= '0;
            if (loop) begin
              state <= S_FETCH;
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              tone_en <= 1'b0;
            end
          end else begin
            tone_idx           <= idx_raw;
            tone_en            <= (idx_raw != 5'd0);
            beat_cnt_parameter <= param_next;
            beat_en            <= 1'b1;
            state              <= S_PLAY;
          end
        end
        S_PLAY: begin
          // The beat counter wraps to 0 on this same edge; dropping beat_en
          // here keeps it parked at 0 for the next note.
          if (beat_finish) begin
            beat_en <= 1'b0;
            if (stop_pend) begin
              state    <= S_IDLE;
              stop_req <= 1'b0;
              busy     <= 1'b0;
              tone_en  <= 1'b0;
            end else if (GAP_CYCLES > 0) begin
              state   <= S_GAP;
              tone_en <= 1'b0;
              gap_cnt <= GAP_LOAD;
            end else begin
              state    <= S_FETCH;
              rom_addr <= rom_addr + ADDR_ONE;
            end
          end
        end
        S_GAP: begin
          if (stop_pend) begin
            state    <= S_IDLE;
            stop_req <= 1'b0;
            busy     <= 1'b0;
          end else if (gap_cnt == 32'd0) begin
            state    <= S_FETCH;
            rom_addr <= rom_addr + ADDR_ONE;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          stop_req <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_seq.sv
module tb_note_seq;

  localparam int TB_UNIT = 4;
  localparam int TB_GAP  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  rom_addr;
  logic [8:0]  rom_data = '0;
  logic        beat_en;
  logic [27:0] beat_cnt_parameter;
  logic        beat_finish;
  logic [4:0]  tone_idx;
  logic        tone_en;
  logic        busy;
  logic        done;

  logic [8:0]  rom [256];
  logic [27:0] bcnt;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [4:0]  idx;
    logic        ten;
    logic [27:0] param;
    int          len;
    logic        ten_var;
    logic [7:0]  addr;
  } note_t;

  note_t exp_q[$];

  note_seq #(.ADDR_W(8), .BEAT_UNIT(TB_UNIT), .GAP_CYCLES(TB_GAP)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .beat_en(beat_en),
    .beat_cnt_parameter(beat_cnt_parameter), .beat_finish(beat_finish),
    .tone_idx(tone_idx), .tone_en(tone_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous score ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // beat counter: counts while enabled, flags and wraps at the terminal count
  always @(posedge clk or negedge rstn) begin
    if (!rstn) bcnt <= '0;
    else if (beat_en) bcnt <= (bcnt == beat_cnt_parameter) ? 28'd0 : bcnt + 28'd1;
  end
  assign beat_finish = beat_en && (bcnt == beat_cnt_parameter);

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic note_t exp_note(input logic [8:0] e, input int addr);
    note_t n;
    int l;
    l = (e[8:5] == 4'd0) ? 1 : int'(e[8:5]);
    n.idx = e[4:0];
    n.ten = (e[4:0] != 5'd0);
    n.param = 28'(l * TB_UNIT - 1);
    n.len = l * TB_UNIT;
    n.ten_var = 1'b0;
    n.addr = 8'(addr);
    return n;
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 9'h01F;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Waits for a note to start and measures it; returns on the first
  // negedge with beat_en low.
  task automatic grab_note(output note_t n, output bit to);
    int k;
    to = 1'b0; k = 0;
    n.len = 0; n.ten_var = 1'b0; n.idx = '0; n.ten = 1'b0; n.param = '0; n.addr = '0;
    while (beat_en !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) begin to = 1'b1; return; end
    n.idx = tone_idx; n.ten = tone_en; n.param = beat_cnt_parameter; n.addr = rom_addr;
    while (beat_en === 1'b1 && n.len < 2000) begin
      if (tone_en !== n.ten) n.ten_var = 1'b1;
      n.len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit to);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
    to = (k >= 2000);
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #5;
    total++;
    if ({beat_en, tone_en, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got be=%b te=%b busy=%b done=%b, want all 0", beat_en, tone_en, busy, done);
    end
    total++;
    if (rom_addr !== 8'd0 || beat_cnt_parameter !== 28'd0 || tone_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_values: got addr=%0d param=%0d idx=%0d, want 0", rom_addr, beat_cnt_parameter, tone_idx);
    end
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_note();
    note_t n, e;
    bit to;
    int g, d0;
    logic muted_bad;
    fill_rom();
    rom[0] = {4'd2, 5'd5};
    exp_q.push_back(exp_note(rom[0], 0));
    d0 = done_cnt;
    pulse_start();
    grab_note(n, to);
    e = exp_q.pop_front();
    total++;
    if (to || n.idx !== e.idx || n.ten !== e.ten || n.param !== e.param || n.len != e.len || n.ten_var !== 1'b0 || n.addr !== e.addr) begin
      bad++;
      $display("FAIL single_note: got idx=%0d te=%b param=%0d len=%0d var=%b addr=%0d to=%b, want idx=%0d te=%b param=%0d len=%0d addr=%0d",
               n.idx, n.ten, n.param, n.len, n.ten_var, n.addr, to, e.idx, e.ten, e.param, e.len, e.addr);
    end
    g = 0; muted_bad = 1'b0;
    while (rom_addr === 8'd0 && g < 50) begin
      if (tone_en !== 1'b0 || beat_en !== 1'b0) muted_bad = 1'b1;
      g++;
      @(negedge clk);
    end
    total++;
    if (g != TB_GAP || muted_bad !== 1'b0) begin
      bad++;
      $display("FAIL single_gap: got gap=%0d muted_bad=%b, want gap=%0d muted_bad=0", g, muted_bad, TB_GAP);
    end
    wait_idle(to);
    total++;
    if (to || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL single_done: got pulses=%0d to=%b, want 1", done_cnt - d0, to);
    end
    total++;
    if (rom_addr !== 8'd0 || tone_en !== 1'b0 || beat_en !== 1'b0) begin
      bad++;
      $display("FAIL single_end_state: got addr=%0d te=%b be=%b, want 0 0 0", rom_addr, tone_en, beat_en);
    end
  endtask

  task automatic test_rest();
    note_t n, e;
    bit to;
    int g;
    fill_rom();
    rom[0] = {4'd1, 5'd0};
    exp_q.push_back(exp_note(rom[0], 0));
    pulse_start();
    grab_note(n, to);
    e = exp_q.pop_front();
    total++;
    if (to || n.idx !== e.idx || n.ten !== e.ten || n.param !== e.param || n.len != e.len || n.ten_var !== 1'b0 || n.addr !== e.addr) begin
      bad++;
      $display("FAIL rest_note: got idx=%0d te=%b param=%0d len=%0d var=%b to=%b, want idx=%0d te=%b param=%0d len=%0d",
               n.idx, n.ten, n.param, n.len, n.ten_var, to, e.idx, e.ten, e.param, e.len);
    end
    g = 0;
    while (rom_addr === 8'd0 && g < 50) begin g++; @(negedge clk); end
    total++;
    if (g != TB_GAP || rom_addr !== 8'd1) begin
      bad++;
      $display("FAIL rest_next_fetch: got gap=%0d addr=%0d, want gap=%0d addr=1", g, rom_addr, TB_GAP);
    end
    wait_idle(to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL rest_idle: got busy=%b after timeout, want 0", busy);
    end
  endtask

  task automatic test_zero_len();
    note_t n, e;
    bit to;
    fill_rom();
    rom[0] = {4'd0, 5'd9};
    exp_q.push_back(exp_note(rom[0], 0));
    pulse_start();
    grab_note(n, to);
    e = exp_q.pop_front();
    total++;
    if (to || n.idx !== e.idx || n.ten !== e.ten || n.param !== e.param || n.len != e.len || n.ten_var !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: got idx=%0d te=%b param=%0d len=%0d to=%b, want idx=%0d te=%b param=%0d len=%0d",
               n.idx, n.ten, n.param, n.len, to, e.idx, e.ten, e.param, e.len);
    end
    wait_idle(to);
  endtask

  task automatic test_stop();
    note_t n, e;
    bit to;
    int d0;
    logic rose;
    fill_rom();
    rom[0] = {4'd3, 5'd7};
    rom[1] = {4'd1, 5'd8};
    exp_q.push_back(exp_note(rom[0], 0));
    d0 = done_cnt;
    pulse_start();
    fork
      grab_note(n, to);
      begin
        int k;
        k = 0;
        while (beat_en !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
      end
    join
    e = exp_q.pop_front();
    total++;
    if (to || n.idx !== e.idx || n.param !== e.param || n.len != e.len) begin
      bad++;
      $display("FAIL stop_note: got idx=%0d param=%0d len=%0d to=%b, want idx=%0d param=%0d len=%0d",
               n.idx, n.param, n.len, to, e.idx, e.param, e.len);
    end
    total++;
    if (busy !== 1'b0 || tone_en !== 1'b0) begin
      bad++;
      $display("FAIL stop_no_gap: got busy=%b te=%b right after note, want 0 0", busy, tone_en);
    end
    rose = 1'b0;
    repeat (20) begin @(negedge clk); if (beat_en !== 1'b0 || busy !== 1'b0) rose = 1'b1; end
    total++;
    if (rose !== 1'b0) begin
      bad++;
      $display("FAIL stop_stays_idle: got activity=%b, want 0", rose);
    end
    total++;
    if (rom_addr !== 8'd0 || done_cnt != d0) begin
      bad++;
      $display("FAIL stop_addr_done: got addr=%0d done_pulses=%0d, want 0 0", rom_addr, done_cnt - d0);
    end
  endtask

  task automatic test_loop();
    note_t n, e;
    bit to;
    int d0;
    fill_rom();
    rom[0] = {4'd1, 5'd3};
    rom[1] = {4'd2, 5'd4};
    loop = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(exp_note(rom[0], 0));
      exp_q.push_back(exp_note(rom[1], 1));
    end
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      grab_note(n, to);
      e = exp_q.pop_front();
      total++;
      if (to || n.idx !== e.idx || n.param !== e.param || n.len != e.len || n.addr !== e.addr) begin
        bad++;
        $display("FAIL loop_note%0d: got idx=%0d param=%0d len=%0d addr=%0d to=%b, want idx=%0d param=%0d len=%0d addr=%0d",
                 i, n.idx, n.param, n.len, n.addr, to, e.idx, e.param, e.len, e.addr);
      end
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(to);
    loop = 1'b0;
    total++;
    if (to || done_cnt != d0) begin
      bad++;
      $display("FAIL loop_no_done: got done_pulses=%0d to=%b, want 0", done_cnt - d0, to);
    end
  endtask

  task automatic test_start_stop();
    logic act;
    act = 1'b0;
    fill_rom();
    rom[0] = {4'd1, 5'd2};
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (10) begin if (busy !== 1'b0 || beat_en !== 1'b0) act = 1'b1; @(negedge clk); end
    total++;
    if (act !== 1'b0) begin
      bad++;
      $display("FAIL start_stop_same: got activity=%b, want 0", act);
    end
  endtask

  task automatic test_back_to_back();
    note_t n, e;
    bit to;
    fill_rom();
    rom[0] = {4'd1, 5'd6};
    rom[1] = {4'd1, 5'd7};
    exp_q.push_back(exp_note(rom[0], 0));
    exp_q.push_back(exp_note(rom[1], 1));
    pulse_start();
    fork
      grab_note(n, to);
      begin
        int k;
        k = 0;
        while (beat_en !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
    join
    for (int i = 0; i < 2; i++) begin
      if (i == 1) grab_note(n, to);
      e = exp_q.pop_front();
      total++;
      if (to || n.idx !== e.idx || n.addr !== e.addr || n.len != e.len) begin
        bad++;
        $display("FAIL b2b_note%0d: got idx=%0d addr=%0d len=%0d to=%b, want idx=%0d addr=%0d len=%0d",
                 i, n.idx, n.addr, n.len, to, e.idx, e.addr, e.len);
      end
    end
    wait_idle(to);
  endtask

  task automatic test_reset_mid();
    note_t n, e;
    bit to;
    int k;
    logic act;
    fill_rom();
    rom[0] = {4'd1, 5'd4};
    rom[1] = {4'd15, 5'd2};
    exp_q.push_back(exp_note(rom[0], 0));
    pulse_start();
    grab_note(n, to);
    e = exp_q.pop_front();
    total++;
    if (to || n.idx !== e.idx || n.param !== e.param || n.len != e.len) begin
      bad++;
      $display("FAIL rmid_first: got idx=%0d param=%0d len=%0d to=%b, want idx=%0d param=%0d len=%0d",
               n.idx, n.param, n.len, to, e.idx, e.param, e.len);
    end
    k = 0;
    while (beat_en !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    total++;
    if (beat_en !== 1'b1 || rom_addr !== 8'd1 || beat_cnt_parameter !== 28'd59 || tone_idx !== 5'd2) begin
      bad++;
      $display("FAIL rmid_playing: got be=%b addr=%0d param=%0d idx=%0d, want 1 1 59 2",
               beat_en, rom_addr, beat_cnt_parameter, tone_idx);
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({beat_en, tone_en, busy, done} !== 4'b0000 || beat_cnt_parameter !== 28'd0 || rom_addr !== 8'd0 || tone_idx !== 5'd0) begin
      bad++;
      $display("FAIL rmid_async: got be=%b te=%b busy=%b done=%b param=%0d addr=%0d idx=%0d, want all 0",
               beat_en, tone_en, busy, done, beat_cnt_parameter, rom_addr, tone_idx);
    end
    @(negedge clk); rstn = 1'b1;
    act = 1'b0;
    repeat (20) begin @(negedge clk); if (busy !== 1'b0 || beat_en !== 1'b0 || tone_en !== 1'b0) act = 1'b1; end
    total++;
    if (act !== 1'b0) begin
      bad++;
      $display("FAIL rmid_stays_idle: got activity=%b, want 0", act);
    end
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_single_note();
    test_rest();
    test_zero_len();
    test_stop();
    test_loop();
    test_start_stop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
